// File: rtl/data_memory_arbiter.sv
// Round-robin, burst-limited arbiter sharing one data_memory port between port A and port B.
// Optional write protection for port B below PROTECT_LIMIT: DATA_MEMORY_ARBITER_PROTECT_EN.
module data_memory_arbiter #(
  parameter int unsigned MAX_BURST = 4
`ifdef DATA_MEMORY_ARBITER_PROTECT_EN
  , parameter logic [29:0] PROTECT_LIMIT = 30'h00000100
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic        a_write_enable,
  input  logic [29:0] a_address,
  input  logic [31:0] a_write_input,
  output logic        a_resp_valid,
  output logic [31:0] a_read_result,
  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic        b_write_enable,
  input  logic [29:0] b_address,
  input  logic [31:0] b_write_input,
  output logic        b_resp_valid,
  output logic [31:0] b_read_result,
  output logic        b_resp_error,
  output logic [29:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_input,
  input  logic [31:0] mem_read_result
);

  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_t;

  localparam logic [3:0] MAX_BURST_W = 4'(MAX_BURST);

  // Handshake: a request moves on a posedge with valid=1 and ready=1; ready is a pure
  // function of both valids and the arbitration state, and is never raised without valid.
  owner_t     last_owner, next_last_owner, grant_owner;
  logic [3:0] burst_count, next_burst_count;
  logic       a_wins_tie, a_grant, b_grant, transfer, grant_we;
  logic [29:0] grant_address;
  logic [31:0] grant_wdata;

  owner_t acc_owner;
  logic   acc_active, acc_we, acc_blocked, grant_blocked;

  always_comb begin
    a_wins_tie = (last_owner == OWNER_A) ? (burst_count <  MAX_BURST_W)
                                         : (burst_count >= MAX_BURST_W);
    a_grant       = a_req_valid && (!b_req_valid || a_wins_tie);
    b_grant       = b_req_valid && (!a_req_valid || !a_wins_tie);
    transfer      = a_grant || b_grant;
    grant_owner   = a_grant ? OWNER_A : OWNER_B;
    grant_we      = a_grant ? a_write_enable : b_write_enable;
    grant_address = a_grant ? a_address : b_address;
    grant_wdata   = a_grant ? a_write_input : b_write_input;
  end

  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;

`ifdef DATA_MEMORY_ARBITER_PROTECT_EN
  assign grant_blocked = b_grant && b_write_enable && (b_address < PROTECT_LIMIT);
`else
  assign grant_blocked = 1'b0;
`endif

  always_comb begin
    next_last_owner  = last_owner;
    next_burst_count = burst_count;
    if (!transfer) begin
      next_burst_count = 4'd0;
    end else if (grant_owner == last_owner) begin
      if (burst_count < MAX_BURST_W) next_burst_count = burst_count + 4'd1;
    end else begin
      next_last_owner  = grant_owner;
      next_burst_count = 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner  <= OWNER_A;
      burst_count <= 4'd0;
    end else begin
      last_owner  <= next_last_owner;
      burst_count <= next_burst_count;
    end
  end

  // Access register: mem_address/mem_write_input keep their last value while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_active      <= 1'b0;
      acc_owner       <= OWNER_A;
      acc_we          <= 1'b0;
      acc_blocked     <= 1'b0;
      mem_address     <= '0;
      mem_write_input <= '0;
    end else begin
      acc_active <= transfer;
      if (transfer) begin
        acc_owner       <= grant_owner;
        acc_we          <= grant_we;
        acc_blocked     <= grant_blocked;
        mem_address     <= grant_address;
        mem_write_input <= grant_wdata;
      end
    end
  end

  assign mem_write_enable = acc_active && acc_we && !acc_blocked;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_resp_valid  <= 1'b0;
      b_resp_valid  <= 1'b0;
      a_read_result <= '0;
      b_read_result <= '0;
    end else begin
      a_resp_valid <= acc_active && (acc_owner == OWNER_A);
      b_resp_valid <= acc_active && (acc_owner == OWNER_B);
      if (acc_active && (acc_owner == OWNER_A) && !acc_we) a_read_result <= mem_read_result;
      if (acc_active && (acc_owner == OWNER_B) && !acc_we) b_read_result <= mem_read_result;
    end
  end

`ifdef DATA_MEMORY_ARBITER_PROTECT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) b_resp_error <= 1'b0;
    else        b_resp_error <= acc_active && (acc_owner == OWNER_B) && acc_blocked;
  end
`else
  assign b_resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus randomized two-port traffic against a
// cycle-level reference model with its own shadow memory.
module tb_data_memory_arbiter;

  localparam int MAX_BURST = 4;
  localparam int MEM_WORDS = 512;
`ifdef DATA_MEMORY_ARBITER_PROTECT_EN
  localparam logic [29:0] PROTECT_LIMIT = 30'h100;
`endif

  logic        clock, reset;
  logic        a_req_valid, a_req_ready, a_write_enable, a_resp_valid;
  logic [29:0] a_address;
  logic [31:0] a_write_input, a_read_result;
  logic        b_req_valid, b_req_ready, b_write_enable, b_resp_valid, b_resp_error;
  logic [29:0] b_address;
  logic [31:0] b_write_input, b_read_result;
  logic [29:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_input, mem_read_result;

  int checks = 0;
  int errors = 0;

  data_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_write_enable(a_write_enable),
    .a_address(a_address), .a_write_input(a_write_input),
    .a_resp_valid(a_resp_valid), .a_read_result(a_read_result),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_write_enable(b_write_enable),
    .b_address(b_address), .b_write_input(b_write_input),
    .b_resp_valid(b_resp_valid), .b_read_result(b_read_result), .b_resp_error(b_resp_error),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_input(mem_write_input), .mem_read_result(mem_read_result)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] preload(input int i);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- data_memory stand-in ----------------
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        mem_loaded = 1'b0;
  assign mem_read_result = mem[mem_address[8:0]];

  always @(negedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= preload(i);
      mem_loaded <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_address[8:0]] <= mem_write_input;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] shadow [0:MEM_WORDS-1];
  logic        shadow_loaded = 1'b0;
  int          cyc = 0;
  int          m_last, m_burst, pref, w;
  logic        p_v, p_we, p_blk, r_v, r_we, r_blk;
  int          p_owner, r_owner;
  logic [29:0] p_addr, m_maddr;
  logic [31:0] p_wdata, r_data, m_mwdata, m_a_rd, m_b_rd;
  logic        exp_a, exp_b, a_fire_last, b_fire_last;
  byte         grant_q[$];
  int          a_xfer_cyc[$], a_resp_cyc[$], b_resp_cyc[$];
  logic [31:0] a_resp_dat[$], b_resp_dat[$];
  logic        b_resp_err[$];

  always @(negedge clock) begin
    if (!shadow_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) shadow[i] = preload(i);
      shadow_loaded = 1'b1;
    end
    if (!reset) begin
      m_last = 0; m_burst = 0; p_v = 1'b0; r_v = 1'b0;
      m_a_rd = '0; m_b_rd = '0; m_maddr = '0; m_mwdata = '0;
      a_fire_last = 1'b0; b_fire_last = 1'b0;
      chk("rst_a_resp_valid", a_resp_valid, 0);
      chk("rst_b_resp_valid", b_resp_valid, 0);
      chk("rst_mem_write_enable", mem_write_enable, 0);
    end else begin
      cyc++;
      // response visible this cycle
      if (r_v && !r_we && r_owner == 0) m_a_rd = r_data;
      if (r_v && !r_we && r_owner == 1) m_b_rd = r_data;
      chk("a_resp_valid", a_resp_valid, r_v && r_owner == 0);
      chk("b_resp_valid", b_resp_valid, r_v && r_owner == 1);
      chk("b_resp_error", b_resp_error, r_v && r_owner == 1 && r_blk);
      chk("a_read_result", a_read_result, m_a_rd);
      chk("b_read_result", b_read_result, m_b_rd);
      if (a_resp_valid) begin a_resp_cyc.push_back(cyc); a_resp_dat.push_back(a_read_result); end
      if (b_resp_valid) begin
        b_resp_cyc.push_back(cyc); b_resp_dat.push_back(b_read_result);
        b_resp_err.push_back(b_resp_error);
      end
      // memory access performed this cycle
      if (p_v) begin m_maddr = p_addr; m_mwdata = p_wdata; end
      chk("mem_write_enable", mem_write_enable, p_v && p_we && !p_blk);
      chk("mem_address", mem_address, m_maddr);
      chk("mem_write_input", mem_write_input, m_mwdata);
      r_v = p_v; r_owner = p_owner; r_we = p_we; r_blk = p_blk;
      if (p_v) begin
        if (p_we && !p_blk) shadow[p_addr[8:0]] = p_wdata;
        r_data = shadow[p_addr[8:0]];
      end
      // arbitration: the port holding the run keeps it until the burst limit is reached
      pref  = (m_burst < MAX_BURST) ? m_last : 1 - m_last;
      exp_a = a_req_valid && (!b_req_valid || pref == 0);
      exp_b = b_req_valid && (!a_req_valid || pref == 1);
      chk("a_req_ready", a_req_ready, exp_a);
      chk("b_req_ready", b_req_ready, exp_b);
      if (exp_a || exp_b) begin
        w = exp_a ? 0 : 1;
        grant_q.push_back(exp_a ? "A" : "B");
        if (exp_a) a_xfer_cyc.push_back(cyc);
        if (w == m_last) m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
        else begin m_last = w; m_burst = 1; end
        p_v = 1'b1; p_owner = w;
        p_we    = exp_a ? a_write_enable : b_write_enable;
        p_addr  = exp_a ? a_address : b_address;
        p_wdata = exp_a ? a_write_input : b_write_input;
        p_blk   = 1'b0;
`ifdef DATA_MEMORY_ARBITER_PROTECT_EN
        p_blk   = exp_b && b_write_enable && (b_address < PROTECT_LIMIT);
`endif
      end else begin
        m_burst = 0;
        p_v = 1'b0;
      end
      a_fire_last = a_req_valid && a_req_ready;
      b_fire_last = b_req_valid && b_req_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_xfer(input logic we, input logic [29:0] addr, input logic [31:0] wd);
    bit done = 1'b0;
    a_req_valid = 1'b1; a_write_enable = we; a_address = addr; a_write_input = wd;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (a_req_ready) done = 1'b1;
      @(posedge clock); #1;
    end
    a_req_valid = 1'b0;
    chk("a_xfer_accepted", done, 1);
  endtask

  task automatic b_xfer(input logic we, input logic [29:0] addr, input logic [31:0] wd);
    bit done = 1'b0;
    b_req_valid = 1'b1; b_write_enable = we; b_address = addr; b_write_input = wd;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (b_req_ready) done = 1'b1;
      @(posedge clock); #1;
    end
    b_req_valid = 1'b0;
    chk("b_xfer_accepted", done, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string       seq;
    logic [31:0] old5;
    reset = 1'b1;
    a_req_valid = 0; a_write_enable = 0; a_address = '0; a_write_input = '0;
    b_req_valid = 0; b_write_enable = 0; b_address = '0; b_write_input = '0;
    #1 reset = 1'b0;
    #11;
    chk("reset_a_resp_valid", a_resp_valid, 0);
    chk("reset_b_resp_valid", b_resp_valid, 0);
    chk("reset_a_read_result", a_read_result, 0);
    chk("reset_b_read_result", b_read_result, 0);
    chk("reset_b_resp_error", b_resp_error, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_write_input", mem_write_input, 0);
    chk("reset_mem_write_enable", mem_write_enable, 0);
    @(posedge clock); @(posedge clock); #1;

    // both ports request continuously from the first cycle after reset
    grant_q.delete();
    a_req_valid = 1; a_write_enable = 0; a_address = 30'h30;
    b_req_valid = 1; b_write_enable = 0; b_address = 30'h31;
    reset = 1'b1;
    repeat (12) @(posedge clock);
    #1 a_req_valid = 0; b_req_valid = 0;
    seq = "AAAABBBBAAAA";
    chk("t2_grant_count", grant_q.size(), 12);
    for (int i = 0; i < 12 && i < grant_q.size(); i++) chk("t2_grant_order", grant_q[i], seq[i]);
    idle(3);

    // port A write then read back
    a_resp_cyc.delete(); a_resp_dat.delete(); a_xfer_cyc.delete();
    a_xfer(1, 30'h10, 32'hDEADBEEF);
    a_xfer(0, 30'h10, 32'h0);
    idle(4);
    chk("t1_resp_count", a_resp_cyc.size(), 2);
    if (a_resp_cyc.size() == 2 && a_xfer_cyc.size() == 2) begin
      chk("t1_read_data", a_resp_dat[1], 32'hDEADBEEF);
      chk("t1_latency", a_resp_cyc[1] - a_xfer_cyc[1], 2);
    end

    // port B three back-to-back reads
    b_resp_cyc.delete(); b_resp_dat.delete(); b_resp_err.delete();
    b_req_valid = 1; b_write_enable = 0;
    for (int i = 0; i < 3; i++) begin
      b_address = 30'h20 + 30'(i);
      @(negedge clock);
      chk("t3_b_ready", b_req_ready, 1);
      @(posedge clock); #1;
    end
    b_req_valid = 0;
    idle(4);
    chk("t3_resp_count", b_resp_cyc.size(), 3);
    for (int i = 0; i < 3 && i < b_resp_cyc.size(); i++) begin
      chk("t3_read_data", b_resp_dat[i], 32'h5A00_0020 + 32'(i));
      chk("t3_consecutive", b_resp_cyc[i] - b_resp_cyc[0], i);
    end

    // port B writes below and at the protection limit
    b_resp_cyc.delete(); b_resp_dat.delete(); b_resp_err.delete();
    b_xfer(1, 30'h0, 32'h1);
    b_xfer(1, 30'h100, 32'hCAFE0100);
    idle(4);
    chk("t5_resp_count", b_resp_err.size(), 2);
    if (b_resp_err.size() == 2) begin
`ifdef DATA_MEMORY_ARBITER_PROTECT_EN
      chk("t5_low_error", b_resp_err[0], 1);
      chk("t5_low_unchanged", mem[0], 32'h5A00_0000);
`else
      chk("t5_low_error", b_resp_err[0], 0);
      chk("t5_low_written", mem[0], 32'h1);
`endif
      chk("t5_high_error", b_resp_err[1], 0);
    end
    chk("t5_high_written", mem[256], 32'hCAFE0100);

    // randomized two-port traffic
    for (int n = 0; n < 500; n++) begin
      if (!a_req_valid || a_fire_last) begin
        a_req_valid    = ($urandom_range(0, 3) != 0);
        a_write_enable = 1'($urandom_range(0, 1));
        a_address      = 30'($urandom_range(0, 63));
        a_write_input  = $urandom;
      end
      if (!b_req_valid || b_fire_last) begin
        b_req_valid    = ($urandom_range(0, 3) != 0);
        b_write_enable = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       b_address = 30'($urandom_range(0, 3));
          1:       b_address = 30'h100 + 30'($urandom_range(0, 3));
          default: b_address = 30'($urandom_range(0, 63));
        endcase
        b_write_input  = $urandom;
      end
      @(posedge clock); #1;
    end
    a_req_valid = 0; b_req_valid = 0;
    idle(4);

    // reset lands between the transfer and the memory write of a port A store
    old5 = mem[5];
    a_req_valid = 1; a_write_enable = 1; a_address = 30'h5; a_write_input = ~old5;
    @(negedge clock);
    chk("t4_ready", a_req_ready, 1);
    @(posedge clock); #1;
    a_req_valid = 0;
    chk("t4_mem_we_active", mem_write_enable, 1);
    chk("t4_mem_address", mem_address, 30'h5);
    a_resp_cyc.delete(); a_resp_dat.delete();
    #1 reset = 1'b0;
    #1 chk("t4_mem_we_drop", mem_write_enable, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    idle(4);
    chk("t4_no_resp", a_resp_cyc.size(), 0);
    chk("t4_word_unchanged", mem[5], old5);

    for (int i = 0; i < MEM_WORDS; i++) chk("final_memory", mem[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
